// File: rtl/jt201d_pkg.sv
// Shared types, ASCII constants and hex conversion helpers for the JT201D
// command sequencer and its response serializer.
package jt201d_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_OP,
        S_SEP1,
        S_ADDR,
        S_SEP2,
        S_DATA,
        S_CLOSE,
        S_SPI_REQ,
        S_SPI_WAIT,
        S_TX
    } seq_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_OPEN,
        TX_DATA,
        TX_CLOSE
    } tx_state_t;

    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_WR     = 8'h61;
    localparam logic [7:0] CH_RD     = 8'h41;

    // Bit 4 flags a valid hex character, bits 3:0 carry its value.
    function automatic logic [4:0] hex2nib(input logic [7:0] ch);
        logic [4:0] res;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            res = {1'b1, ch[3:0]};
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            res = {1'b1, ch[3:0] + 4'd9};
        end else begin
            res = 5'b0_0000;
        end
        return res;
    endfunction

    function automatic logic [7:0] nib2hex(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/jt201d_rsp_tx.sv
// Serializes a read result as "{" + upper-case hex digits (MSB first) + "}"
// over a valid/ready byte handshake; pulses done after the closing brace.
module jt201d_rsp_tx
    import jt201d_pkg::*;
#(
    parameter  int DATA_DIGITS = 5,
    localparam int DATA_W      = 4 * DATA_DIGITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] rdata,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_DIGITS + 1);

    tx_state_t         state_r, state_s;
    logic [DATA_W-1:0] shift_r, shift_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [7:0]        data_r, data_s;
    logic              valid_r, valid_s;
    logic              done_r, done_s;

    // Next-state and next-byte selection; a byte advances only on handshake.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        cnt_s   = cnt_r;
        data_s  = data_r;
        valid_s = valid_r;
        done_s  = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (start) begin
                    state_s = TX_OPEN;
                    shift_s = rdata;
                    cnt_s   = '0;
                    data_s  = CH_LBRACE;
                    valid_s = 1'b1;
                end else begin
                    state_s = TX_IDLE;
                end
            end
            TX_OPEN: begin
                if (tx_ready) begin
                    state_s = TX_DATA;
                    data_s  = nib2hex(shift_r[DATA_W-1 -: 4]);
                    shift_s = shift_r << 4;
                end else begin
                    state_s = TX_OPEN;
                end
            end
            TX_DATA: begin
                if (tx_ready) begin
                    if (cnt_r == CNT_W'(DATA_DIGITS - 1)) begin
                        state_s = TX_CLOSE;
                        data_s  = CH_RBRACE;
                    end else begin
                        data_s  = nib2hex(shift_r[DATA_W-1 -: 4]);
                        shift_s = shift_r << 4;
                        cnt_s   = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = TX_DATA;
                end
            end
            TX_CLOSE: begin
                if (tx_ready) begin
                    state_s = TX_IDLE;
                    data_s  = 8'h00;
                    valid_s = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = TX_CLOSE;
                end
            end
            default: begin
                state_s = TX_IDLE;
                data_s  = 8'h00;
                valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= TX_IDLE;
            shift_r <= '0;
            cnt_r   <= '0;
            data_r  <= 8'h00;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            cnt_r   <= cnt_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            done_r  <= done_s;
        end
    end

    assign tx_data  = data_r;
    assign tx_valid = valid_r;
    assign done     = done_r;

endmodule

// File: rtl/jt201d_cmd_sequencer.sv
// Parses "{a|A:AAA:DDDDD}" UART command frames, runs one SPI transaction per
// frame and hands read results to the response serializer.
module jt201d_cmd_sequencer
    import jt201d_pkg::*;
#(
    parameter  int ADDR_DIGITS  = 3,
    parameter  int DATA_DIGITS  = 5,
    parameter  int CHAR_TIMEOUT = 20000,
    parameter  int SPI_TIMEOUT  = 4096,
    localparam int ADDR_W       = 4 * ADDR_DIGITS,
    localparam int DATA_W       = 4 * DATA_DIGITS
) (
    input  logic              i_clk_sys,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_spi_start,
    output logic              o_spi_rw,
    output logic [ADDR_W-1:0] o_spi_addr,
    output logic [DATA_W-1:0] o_spi_wdata,
    input  logic              i_spi_busy,
    input  logic              i_spi_done,
    input  logic [DATA_W-1:0] i_spi_rdata,
    output logic              o_parity,
    output logic              o_err,
    output logic              o_busy
);

    localparam int MAX_DIG = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
    localparam int DIG_W   = $clog2(MAX_DIG + 1);
    localparam int CT_W    = $clog2(CHAR_TIMEOUT + 2);
    localparam int ST_W    = $clog2(SPI_TIMEOUT + 1);

    seq_state_t        state_r, state_s;
    logic              rw_r, rw_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] data_r, data_s;
    logic [DIG_W-1:0]  dig_r, dig_s;
    logic [CT_W-1:0]   ctmr_r, ctmr_s;
    logic [ST_W-1:0]   stmr_r, stmr_s;
    logic              start_r, start_s;
    logic              err_r, err_s;
    logic              parity_r, parity_s;
    logic              busy_r;
    logic              tx_start_s;
    logic              tx_done_s;
    logic              parse_s;
    logic [4:0]        hex_s;

    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // Frame parser, character/SPI timers and SPI handshake sequencing.
    always_comb begin
        state_s    = state_r;
        rw_s       = rw_r;
        addr_s     = addr_r;
        data_s     = data_r;
        dig_s      = dig_r;
        stmr_s     = stmr_r;
        start_s    = 1'b0;
        err_s      = 1'b0;
        parity_s   = parity_r;
        tx_start_s = 1'b0;
        hex_s      = hex2nib(i_rx_data);
        parse_s    = (state_r inside {S_OP, S_SEP1, S_ADDR, S_SEP2, S_DATA, S_CLOSE});
        ctmr_s     = (parse_s && !i_rx_valid) ? ctmr_r + CT_W'(1) : '0;

        // A fresh '{' inside a frame restarts parsing; it outranks every other byte check.
        if (parse_s && i_rx_valid && i_rx_data == CH_LBRACE) begin
            err_s   = 1'b1;
            state_s = S_OP;
        end else if (parse_s && !i_rx_valid && ctmr_r > CT_W'(CHAR_TIMEOUT)) begin
            err_s   = 1'b1;
            ctmr_s  = '0;
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (i_rx_valid && i_rx_data == CH_LBRACE) state_s = S_OP;
                    else state_s = S_IDLE;
                end
                S_OP: begin
                    if (!i_rx_valid) begin
                        state_s = S_OP;
                    end else if (i_rx_data == CH_WR) begin
                        rw_s = 1'b0; state_s = S_SEP1;
                    end else if (i_rx_data == CH_RD) begin
                        rw_s = 1'b1; state_s = S_SEP1;
                    end else begin
                        err_s = 1'b1; state_s = S_IDLE;
                    end
                end
                S_SEP1, S_SEP2: begin
                    if (!i_rx_valid) begin
                        state_s = state_r;
                    end else if (i_rx_data == CH_COLON) begin
                        dig_s   = '0;
                        state_s = (state_r == S_SEP1) ? S_ADDR : S_DATA;
                    end else begin
                        err_s = 1'b1; state_s = S_IDLE;
                    end
                end
                S_ADDR: begin
                    if (!i_rx_valid) begin
                        state_s = S_ADDR;
                    end else if (!hex_s[4]) begin
                        err_s = 1'b1; state_s = S_IDLE;
                    end else begin
                        addr_s = {addr_r[ADDR_W-5:0], hex_s[3:0]};
                        if (dig_r == DIG_W'(ADDR_DIGITS - 1)) begin
                            dig_s = '0; state_s = S_SEP2;
                        end else begin
                            dig_s = dig_r + DIG_W'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (!i_rx_valid) begin
                        state_s = S_DATA;
                    end else if (!hex_s[4]) begin
                        err_s = 1'b1; state_s = S_IDLE;
                    end else begin
                        data_s = {data_r[DATA_W-5:0], hex_s[3:0]};
                        if (dig_r == DIG_W'(DATA_DIGITS - 1)) begin
                            dig_s = '0; state_s = S_CLOSE;
                        end else begin
                            dig_s = dig_r + DIG_W'(1);
                        end
                    end
                end
                S_CLOSE: begin
                    if (!i_rx_valid) state_s = S_CLOSE;
                    else if (i_rx_data == CH_RBRACE) state_s = S_SPI_REQ;
                    else begin err_s = 1'b1; state_s = S_IDLE; end
                end
                S_SPI_REQ: begin
                    if (!i_spi_busy) begin
                        start_s = 1'b1; stmr_s = '0; state_s = S_SPI_WAIT;
                    end else begin
                        state_s = S_SPI_REQ;
                    end
                end
                // Done is tested before the timeout so a coincident strobe still completes.
                S_SPI_WAIT: begin
                    if (i_spi_done) begin
                        if (rw_r) begin
                            parity_s   = parity_of(i_spi_rdata);
                            tx_start_s = 1'b1;
                            state_s    = S_TX;
                        end else begin
                            state_s = S_IDLE;
                        end
                    end else if (stmr_r == ST_W'(SPI_TIMEOUT)) begin
                        err_s = 1'b1; state_s = S_IDLE;
                    end else begin
                        stmr_s = stmr_r + ST_W'(1);
                    end
                end
                S_TX: begin
                    if (tx_done_s) state_s = S_IDLE;
                    else state_s = S_TX;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state_r  <= S_IDLE;
            rw_r     <= 1'b0;
            addr_r   <= '0;
            data_r   <= '0;
            dig_r    <= '0;
            ctmr_r   <= '0;
            stmr_r   <= '0;
            start_r  <= 1'b0;
            err_r    <= 1'b0;
            parity_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            rw_r     <= rw_s;
            addr_r   <= addr_s;
            data_r   <= data_s;
            dig_r    <= dig_s;
            ctmr_r   <= ctmr_s;
            stmr_r   <= stmr_s;
            start_r  <= start_s;
            err_r    <= err_s;
            parity_r <= parity_s;
            busy_r   <= (state_s != S_IDLE);
        end
    end

    jt201d_rsp_tx #(
        .DATA_DIGITS(DATA_DIGITS)
    ) u_rsp_tx (
        .clk      (i_clk_sys),
        .rst      (i_rst),
        .start    (tx_start_s),
        .rdata    (i_spi_rdata),
        .tx_ready (i_tx_ready),
        .tx_data  (o_tx_data),
        .tx_valid (o_tx_valid),
        .done     (tx_done_s)
    );

    assign o_spi_start = start_r;
    assign o_spi_rw    = rw_r;
    assign o_spi_addr  = addr_r;
    assign o_spi_wdata = data_r;
    assign o_parity    = parity_r;
    assign o_err       = err_r;
    assign o_busy      = busy_r;

endmodule

// File: tb/tb_jt201d_cmd_sequencer.sv
// Directed bench for jt201d_cmd_sequencer: a frame table plus hand-written
// sequences for SPI backpressure, timeouts, slow TX and mid-response reset.
module tb_jt201d_cmd_sequencer;

    localparam int CT = 200;
    localparam int ST = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        spi_start;
    logic        spi_rw;
    logic [11:0] spi_addr;
    logic [19:0] spi_wdata;
    logic        spi_busy = 1'b0;
    logic        spi_done = 1'b0;
    logic [19:0] spi_rdata = 20'h0;
    logic        parity;
    logic        err;
    logic        busy;

    always #5 clk = ~clk;

    jt201d_cmd_sequencer #(
        .CHAR_TIMEOUT(CT),
        .SPI_TIMEOUT (ST)
    ) dut (
        .i_clk_sys  (clk),
        .i_rst      (rst),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_spi_start(spi_start),
        .o_spi_rw   (spi_rw),
        .o_spi_addr (spi_addr),
        .o_spi_wdata(spi_wdata),
        .i_spi_busy (spi_busy),
        .i_spi_done (spi_done),
        .i_spi_rdata(spi_rdata),
        .o_parity   (parity),
        .o_err      (err),
        .o_busy     (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Event log taken on the falling edge.
    int          cyc = 0;
    int          start_cnt = 0, err_cnt = 0, tx_total = 0;
    int          start_cyc = 0, err_cyc = 0, rx_cyc = 0;
    logic        last_rw;
    logic [11:0] last_addr;
    logic [19:0] last_wdata;
    logic [7:0]  tx_log [0:255];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (spi_start) begin
            start_cnt  <= start_cnt + 1;
            start_cyc  <= cyc;
            last_rw    <= spi_rw;
            last_addr  <= spi_addr;
            last_wdata <= spi_wdata;
        end
        if (err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (tx_valid && tx_ready) begin
            tx_log[tx_total] <= tx_data;
            tx_total         <= tx_total + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_cyc   = cyc;
        tick(1);
        rx_valid = 1'b0;
        tick(1);
    endtask

    task automatic send_frame(input logic [159:0] t, input int len);
        for (int i = 0; i < len; i++) send_byte(t[8*(len-1-i) +: 8]);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            tick(1);
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    // SPI slave model: done with programmed read data three cycles after start.
    logic        spi_auto = 1'b1;
    logic [19:0] spi_rdata_val = 20'h0;
    initial begin
        forever begin
            @(negedge clk);
            if (spi_start && spi_auto) begin
                tick(3);
                spi_rdata = spi_rdata_val;
                spi_done  = 1'b1;
                tick(1);
                spi_done  = 1'b0;
                spi_rdata = 20'h0;
            end
        end
    end

    // UART TX model: always ready, or 50 stalled cycles per byte when slow.
    logic tx_slow = 1'b0;
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!tx_slow) begin
                tx_ready = 1'b1;
            end else if (tx_ready) begin
                tx_ready = 1'b0;
                wcnt     = 0;
            end else if (tx_valid) begin
                wcnt++;
                if (wcnt >= 50) tx_ready = 1'b1;
            end
        end
    end

    typedef struct {
        logic [159:0] text;
        int           len;
        logic [19:0]  rdata;
        int           n_start;
        logic         rw;
        logic [11:0]  addr;
        logic [19:0]  wdata;
        int           n_err;
        logic [63:0]  tx;
        int           tx_len;
        logic         par;
    } vec_t;

    vec_t        vecs [9];
    int          s0, e0, t0, d;
    logic [63:0] got;
    logic        pv, pr;
    logic [7:0]  pd;

    initial begin
        vecs[0] = '{160'("{a:3CD:1aAfF}"),      13, 20'h00000, 1, 1'b0, 12'h3CD, 20'h1AAFF, 0, 64'h0,              0, 1'b0};
        vecs[1] = '{160'("{A:3CD:ABCDE}"),      13, 20'h12345, 1, 1'b1, 12'h3CD, 20'hABCDE, 0, 64'("{12345}"),    7, 1'b1};
        vecs[2] = '{160'("{a:3G"),               5, 20'h00000, 0, 1'b0, 12'h000, 20'h00000, 1, 64'h0,              0, 1'b1};
        vecs[3] = '{160'("{a:3C{A:001:00000}"), 18, 20'h0F0F0, 1, 1'b1, 12'h001, 20'h00000, 1, 64'("{0F0F0}"),    7, 1'b0};
        vecs[4] = '{160'("xy}{a:001:fedcb}"),   16, 20'h00000, 1, 1'b0, 12'h001, 20'hFEDCB, 0, 64'h0,              0, 1'b0};
        vecs[5] = '{160'("{b"),                  2, 20'h00000, 0, 1'b0, 12'h000, 20'h00000, 1, 64'h0,              0, 1'b0};
        vecs[6] = '{160'("{a:123:4567}"),       12, 20'h00000, 0, 1'b0, 12'h000, 20'h00000, 1, 64'h0,              0, 1'b0};
        vecs[7] = '{160'("{A:ABC:00000}"),      13, 20'hA5B6C, 1, 1'b1, 12'hABC, 20'h00000, 0, 64'("{A5B6C}"),    7, 1'b1};
        vecs[8] = '{160'("{a:FFF:00001}"),      13, 20'h00000, 1, 1'b0, 12'hFFF, 20'h00001, 0, 64'h0,              0, 1'b1};

        tick(3);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_spi_start", spi_start, 1'b0);
        chk("rst_addr", spi_addr, 12'h000);
        chk("rst_parity", parity, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 9; i++) begin
            s0 = start_cnt; e0 = err_cnt; t0 = tx_total;
            spi_rdata_val = vecs[i].rdata;
            send_frame(vecs[i].text, vecs[i].len);
            tick(2);
            wait_idle($sformatf("v%0d_idle", i), 200);
            tick(1);
            chk($sformatf("v%0d_starts", i), start_cnt - s0, vecs[i].n_start);
            chk($sformatf("v%0d_errs", i), err_cnt - e0, vecs[i].n_err);
            if (vecs[i].n_start > 0) begin
                chk($sformatf("v%0d_rw", i), last_rw, vecs[i].rw);
                chk($sformatf("v%0d_addr", i), last_addr, vecs[i].addr);
                chk($sformatf("v%0d_wdata", i), last_wdata, vecs[i].wdata);
            end
            chk($sformatf("v%0d_tx_len", i), tx_total - t0, vecs[i].tx_len);
            got = 64'h0;
            for (int k = 0; k < tx_total - t0 && k < 8; k++) got = {got[55:0], tx_log[t0 + k]};
            chk($sformatf("v%0d_tx_bytes", i), got, vecs[i].tx);
            chk($sformatf("v%0d_parity", i), parity, vecs[i].par);
            if (i == 0) chk("start_latency", start_cyc - rx_cyc, 2);
        end

        // SPI master busy holds the request back.
        spi_busy = 1'b1;
        s0 = start_cnt;
        send_frame(160'("{a:010:00002}"), 13);
        tick(10);
        chk("busy_hold_start", start_cnt - s0, 0);
        chk("busy_hold_busy", busy, 1'b1);
        spi_busy = 1'b0;
        tick(4);
        chk("busy_release_start", start_cnt - s0, 1);
        wait_idle("busy_release_idle", 50);

        // Silence mid-frame.
        e0 = err_cnt;
        send_frame(160'("{a:3C"), 5);
        for (int n = 0; n < CT + 50 && err_cnt == e0; n++) tick(1);
        chk("char_to_err", err_cnt - e0, 1);
        d = err_cyc - rx_cyc;
        chk("char_to_window", (d >= CT + 1 && d <= CT + 4), 1'b1);
        tick(1);
        chk("char_to_busy", busy, 1'b0);

        // SPI done never arrives.
        spi_auto = 1'b0;
        e0 = err_cnt; s0 = start_cnt; t0 = tx_total;
        send_frame(160'("{A:020:00000}"), 13);
        for (int n = 0; n < ST + 50 && err_cnt == e0; n++) tick(1);
        chk("spi_to_err", err_cnt - e0, 1);
        chk("spi_to_start", start_cnt - s0, 1);
        d = err_cyc - start_cyc;
        chk("spi_to_window", (d >= ST && d <= ST + 2), 1'b1);
        tick(2);
        chk("spi_to_busy", busy, 1'b0);
        chk("spi_to_no_tx", tx_total - t0, 0);
        spi_auto = 1'b1;

        // Slow UART TX; bytes arriving during the response are dropped silently.
        tx_slow = 1'b1;
        e0 = err_cnt; s0 = start_cnt; t0 = tx_total;
        spi_rdata_val = 20'hFFFFF;
        send_frame(160'("{A:012:00000}"), 13);
        tick(20);
        send_byte(8'h7B);
        send_byte(8'h61);
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if (pv && !pr) begin
                chk("tx_hold_valid", tx_valid, 1'b1);
                chk("tx_hold_data", tx_data, pd);
            end
            pv = tx_valid; pr = tx_ready; pd = tx_data;
            if (tx_total - t0 == 7 && !busy) break;
        end
        tick(1);
        chk("slow_tx_len", tx_total - t0, 7);
        got = 64'h0;
        for (int k = 0; k < 7; k++) got = {got[55:0], tx_log[t0 + k]};
        chk("slow_tx_bytes", got, 64'("{FFFFF}"));
        chk("slow_errs", err_cnt - e0, 0);
        chk("slow_starts", start_cnt - s0, 1);
        chk("slow_parity", parity, 1'b0);

        // Reset in the middle of a response.
        t0 = tx_total;
        spi_rdata_val = 20'h00001;
        send_frame(160'("{A:FFF:00000}"), 13);
        for (int n = 0; n < 1000 && tx_total - t0 < 3; n++) tick(1);
        chk("midtx_partial", tx_total - t0, 3);
        chk("midtx_parity_set", parity, 1'b1);
        rst = 1'b1;
        tick(1);
        chk("midtx_rst_valid", tx_valid, 1'b0);
        chk("midtx_rst_data", tx_data, 8'h00);
        chk("midtx_rst_busy", busy, 1'b0);
        chk("midtx_rst_parity", parity, 1'b0);
        chk("midtx_rst_err", err, 1'b0);
        chk("midtx_rst_rw", spi_rw, 1'b0);
        chk("midtx_rst_addr", spi_addr, 12'h000);
        rst = 1'b0;
        tx_slow = 1'b0;
        tick(3);

        s0 = start_cnt;
        send_frame(160'("{a:ABC:12345}"), 13);
        tick(2);
        wait_idle("post_rst_idle", 50);
        tick(1);
        chk("post_rst_start", start_cnt - s0, 1);
        chk("post_rst_wdata", last_wdata, 20'h12345);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
